// File: rtl/imm_encoder_pkg.sv
// ---------------------------------------------------------------------------
// imm_encoder_pkg : format codes, funct/opcode constants, encode helper | Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package imm_encoder_pkg;

  typedef enum logic [1:0] {
    I_TYPE = 2'd0,
    S_TYPE = 2'd1,
    B_TYPE = 2'd2,
    J_TYPE = 2'd3
  } imm_sel_e;

  localparam logic [2:0] FUNCT3_SLL     = 3'b001;
  localparam logic [2:0] FUNCT3_SRL_SRA = 3'b101;
  localparam logic [6:0] OPCODE_JAL     = 7'b1101111;

  typedef struct packed {
    logic [31:0] word;
    logic        err;
  } enc_result_t;

  function automatic logic is_shift(input logic [1:0] sel, input logic [2:0] funct3);
    return (sel == I_TYPE) && ((funct3 == FUNCT3_SLL) || (funct3 == FUNCT3_SRL_SRA));
  endfunction

  function automatic logic is_upper(input logic [1:0] sel, input logic [6:0] opcode);
    return (sel == J_TYPE) && (opcode != OPCODE_JAL);
  endfunction

  function automatic enc_result_t encode(
    input logic [1:0]  sel,
    input logic [6:0]  opcode,
    input logic [2:0]  funct3,
    input logic [6:0]  funct7,
    input logic [4:0]  rd,
    input logic [4:0]  rs1,
    input logic [4:0]  rs2,
    input logic [31:0] imm
  );
    enc_result_t r;
    r.word = '0;
    r.err  = 1'b0;
    // Range checks: the bits above the format's sign bit must all equal it.
    case (sel)
      I_TYPE: begin
        if (is_shift(sel, funct3)) begin
          r.word = {funct7, imm[4:0], rs1, funct3, rd, opcode};
          r.err  = |imm[31:5];
        end else begin
          r.word = {imm[11:0], rs1, funct3, rd, opcode};
          r.err  = !((&imm[31:11]) || (~|imm[31:11]));
        end
      end
      S_TYPE: begin
        r.word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
        r.err  = !((&imm[31:11]) || (~|imm[31:11]));
      end
      B_TYPE: begin
        r.word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
        r.err  = imm[0] || !((&imm[31:12]) || (~|imm[31:12]));
      end
      default: begin
        if (opcode == OPCODE_JAL) begin
          r.word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
          r.err  = imm[0] || !((&imm[31:20]) || (~|imm[31:20]));
        end else begin
          r.word = {imm[31:12], rd, opcode};
          r.err  = |imm[11:0];
        end
      end
    endcase
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/enc_fifo.sv
// ---------------------------------------------------------------------------
// enc_fifo : DEPTH x WIDTH synchronous FIFO with flush and push/pop overlap | Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module enc_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      cnt;
  logic             do_push;
  logic             do_pop;

  assign full     = (cnt == FULL_CNT);
  assign empty    = (cnt == '0);
  assign count    = cnt;
  assign do_pop   = pop & !empty;
  assign do_push  = push & (!full | do_pop);
  // Head forced to zero when empty so the port never shows stale storage.
  assign pop_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + (AW + 1)'(1);
        2'b01:   cnt <= cnt - (AW + 1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

endmodule

`default_nettype wire

// File: rtl/imm_gen.sv
// ---------------------------------------------------------------------------
// imm_gen : immediate decoder used for round-trip checking
//           (built only with IMM_ENCODER_ROUNDTRIP_CHECK_EN) | Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

`ifdef IMM_ENCODER_ROUNDTRIP_CHECK_EN
module imm_gen
  import imm_encoder_pkg::*;
(
  input  logic [31:0] instr,
  input  logic [1:0]  imm_sel,
  output logic [31:0] imm
);

  always_comb begin
    imm = '0;
    case (imm_sel)
      I_TYPE:  imm = {{20{instr[31]}}, instr[31:20]};
      S_TYPE:  imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      B_TYPE:  imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      default: begin
        if (instr[6:0] == OPCODE_JAL)
          imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
        else
          imm = {instr[31:12], 12'b0};
      end
    endcase
  end

endmodule
`endif

`default_nettype wire

// File: rtl/imm_encoder.sv
// ---------------------------------------------------------------------------
// imm_encoder : packs RV32I fields + immediate into an instruction word, FIFO-buffered.
//               Optional round-trip check: IMM_ENCODER_ROUNDTRIP_CHECK_EN | Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module imm_encoder
  import imm_encoder_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_imm_sel,
  input  logic [6:0]       req_opcode,
  input  logic [2:0]       req_funct3,
  input  logic [6:0]       req_funct7,
  input  logic [4:0]       req_rd,
  input  logic [4:0]       req_rs1,
  input  logic [4:0]       req_rs2,
  input  logic [31:0]      req_imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instruction,
  output logic             imm_err,
`ifdef IMM_ENCODER_ROUNDTRIP_CHECK_EN
  output logic             check_fail,
`endif
  output logic [CNT_W-1:0] accept_cnt,
  output logic [CNT_W-1:0] reject_cnt
);

  localparam int          CW      = $clog2(DEPTH) + 1;
  localparam logic [CW:0] DEPTH_V = (CW + 1)'(DEPTH);

  enc_result_t   enc;
  logic          alive;
  logic          s1_valid;
  logic          s1_err;
  logic [31:0]   s1_word;
  logic          s1_pend;
  logic          accept;
  logic          push;
  logic          pop;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  logic [CW:0]   occupancy;

  assign enc = encode(req_imm_sel, req_opcode, req_funct3, req_funct7,
                      req_rd, req_rs1, req_rs2, req_imm);

  assign out_valid = !fifo_empty;
  assign pop       = out_valid & out_ready;
  assign s1_pend   = s1_valid & !s1_err;
  // A word parked in stage 1 already owns a FIFO slot, so a push can never find it full.
  assign occupancy = {1'b0, fifo_count} + {{CW{1'b0}}, s1_pend};
  assign req_ready = alive & !flush & ((occupancy < DEPTH_V) | pop);
  assign accept    = req_valid & req_ready;
  assign push      = s1_pend & (!fifo_full | pop) & !flush;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_err   <= 1'b0;
      s1_word  <= '0;
    end else if (flush) begin
      s1_valid <= 1'b0;
      s1_err   <= 1'b0;
    end else if (accept) begin
      s1_valid <= 1'b1;
      s1_err   <= enc.err;
      s1_word  <= enc.word;
    end else if (push || s1_err) begin
      s1_valid <= 1'b0;
      s1_err   <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alive      <= 1'b0;
      imm_err    <= 1'b0;
      accept_cnt <= '0;
      reject_cnt <= '0;
    end else begin
      alive   <= 1'b1;
      imm_err <= accept & enc.err;
      if (accept && !enc.err && !(&accept_cnt)) accept_cnt <= accept_cnt + CNT_W'(1);
      if (accept &&  enc.err && !(&reject_cnt)) reject_cnt <= reject_cnt + CNT_W'(1);
    end
  end

  enc_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk       (clk),
    .rst       (reset),
    .flush     (flush),
    .push      (push),
    .push_data (s1_word),
    .pop       (pop),
    .pop_data  (out_instruction),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

`ifdef IMM_ENCODER_ROUNDTRIP_CHECK_EN
  logic [31:0] s1_imm;
  logic [31:0] gen_imm;
  logic [1:0]  s1_sel;
  logic        s1_shift;
  logic        s1_upper;
  logic        mismatch;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_imm   <= '0;
      s1_sel   <= '0;
      s1_shift <= 1'b0;
      s1_upper <= 1'b0;
    end else if (accept) begin
      s1_imm   <= req_imm;
      s1_sel   <= req_imm_sel;
      s1_shift <= is_shift(req_imm_sel, req_funct3);
      s1_upper <= is_upper(req_imm_sel, req_opcode);
    end
  end

  imm_gen u_imm_gen (
    .instr   (s1_word),
    .imm_sel (s1_sel),
    .imm     (gen_imm)
  );

  always_comb begin
    mismatch = 1'b0;
    if (s1_shift)      mismatch = (gen_imm[4:0]   != s1_imm[4:0]);
    else if (s1_upper) mismatch = (gen_imm[31:12] != s1_imm[31:12]);
    else               mismatch = (gen_imm        != s1_imm);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                    check_fail <= 1'b0;
    else if (s1_pend && mismatch) check_fail <= 1'b1;
  end
`endif

endmodule

`default_nettype wire

// File: doc/imm_encoder.md
Name: imm_encoder

Overview:
- Inverse of the core's immediate decode path: packs opcode, funct, register fields and a 32-bit signed immediate into a legal RV32I instruction word.
- Range-checks the immediate against the selected format and buffers encoded words in a small FIFO for a program loader or self-test sequencer to write into instruction memory.
- Sits between the loader/debug front end and the IMEM write port.

Parameters:
- DEPTH, 4, output FIFO entries (power of two, >=2).
- CNT_W, 16, width of the accepted/rejected counters.

Ports:
- Clk  input  1  core clock
- Reset  input  1  asynchronous, active-high reset
- Flush  input  1  synchronous clear of FIFO contents; counters kept
- Req_Valid  input  1  request valid
- Req_Ready  output  1  block can accept a request
- Req_Imm_Sel  input  2  format select; uses `I_TYPE/`S_TYPE/`B_TYPE/`J_TYPE codes from defines.vh
- Req_Opcode  input  7  instruction[6:0]
- Req_Funct3  input  3  instruction[14:12] (ignored for J_TYPE)
- Req_Funct7  input  7  used only for I-type shifts
- Req_Rd  input  5  destination register
- Req_Rs1  input  5  source register 1
- Req_Rs2  input  5  source register 2
- Req_Imm  input  32  signed immediate (byte offset for B/JAL; full value for LUI/AUIPC)
- Out_Valid  output  1  FIFO head valid
- Out_Ready  input  1  consumer takes head
- Out_Instruction  output  32  encoded word at FIFO head
- Imm_Err  output  1  one-cycle pulse, cycle after a rejected request
- Accept_Cnt  output  CNT_W  requests encoded
- Reject_Cnt  output  CNT_W  requests rejected

Behaviour:
- Reset values: all outputs 0; Req_Ready is 1 one cycle after Reset deasserts. FIFO is empty, counters are 0.
- Handshake: a transfer happens when Req_Valid & Req_Ready at a rising Clk edge. Req_Ready = !full | (Out_Valid & Out_Ready), i.e. a simultaneous pop frees a slot. Out_Instruction must be stable while Out_Valid & !Out_Ready.
- Latency: a word accepted at edge N is visible at the FIFO head after edge N+1 when the FIFO was empty. Sustained throughput is 1 word per cycle.
- Encoding is registered: stage 1 latches fields and computes word + error; stage 2 pushes the word into the FIFO. Stage-1 stall is tracked so no word is dropped when full.
- I_TYPE, funct3 = `FUNCT3_SLL or `FUNCT3_SRL_SRA:
  - word = {Funct7, Imm[4:0], Rs1, Funct3, Rd, Opcode}.
  - Error if Imm > 31 unsigned.
- I_TYPE, other funct3:
  - word = {Imm[11:0], Rs1, Funct3, Rd, Opcode}.
  - Error unless Imm[31:11] is all zeros or all ones.
- S_TYPE:
  - word = {Imm[11:5], Rs2, Rs1, Funct3, Imm[4:0], Opcode}.
  - Same 12-bit signed range as I_TYPE.
- B_TYPE:
  - word = {Imm[12], Imm[10:5], Rs2, Rs1, Funct3, Imm[4:1], Imm[11], Opcode}.
  - Error if Imm[0] = 1 or Imm is outside the 13-bit signed range.
- J_TYPE, Opcode = 7'b1101111 (JAL):
  - word = {Imm[20], Imm[10:1], Imm[11], Imm[19:12], Rd, Opcode}.
  - Error if Imm[0] = 1 or Imm is outside the 21-bit signed range.
- J_TYPE, other opcode (LUI/AUIPC):
  - word = {Imm[31:12], Rd, Opcode}.
  - Error if Imm[11:0] != 0.
- Rejected request: consumes the handshake, never enters the FIFO, pulses Imm_Err, increments Reject_Cnt. Accepted request increments Accept_Cnt.
- Counters saturate at all-ones; they do not wrap.
- FIFO pointers wrap modulo DEPTH. Push on full is impossible by construction; pop on empty is ignored.
- Flush:
  - Empties the FIFO and stage 1 at the next edge and overrides a same-cycle push/pop.
  - Req_Ready is forced 0 during the Flush cycle.
  - Counters are not cleared.
- Reset mid-operation: everything clears immediately (asynchronous); in-flight words are lost.

Optional Feature:
- Macro: IMM_ENCODER_ROUNDTRIP_CHECK_EN.
- Defined:
  - Instantiates imm_gen on stage-1's word with the same Imm_Sel.
  - Compares against Req_Imm; shifts compare Imm[4:0] only, LUI/AUIPC compare Imm[31:12].
  - Mismatch on a non-rejected word raises sticky output Check_Fail (1 bit, cleared only by Reset).
- Undefined: no Check_Fail port and no imm_gen instance; behaviour otherwise identical.

Decomposition:
- Format codes, FUNCT3_* and the JAL opcode constant come from the shared defines.vh; add OPCODE_JAL there if absent.
- Natural sub-module: enc_fifo (parameterised DEPTH x 32 synchronous FIFO with flush, full/empty, simultaneous push/pop).

Test Plan:
- I-type: ADDI, Req_Imm=-1, Rs1=2, Rd=1, Funct3=0, Opcode=0x13 -> Out_Instruction=0xFFF10093 one cycle after accept; Accept_Cnt=1.
- Shift: SRAI, Funct7=0x20, Req_Imm=40 -> Imm_Err pulse, Reject_Cnt=1, FIFO stays empty. Same request with Imm=3 -> 0x4030D093 pattern for Rs1=1, Rd=1, Funct3=5.
- B/J encoding:
  - BEQ with Imm=-4 -> 0xFE000EE3 field layout (Rs1=Rs2=0).
  - JAL with Imm=2048, Rd=1 -> 0x001000EF.
  - JAL with Imm=3 -> Imm_Err.
- LUI: Imm=0x12345000, Rd=5 -> 0x123452B7. Imm=0x12345001 -> rejected.
- Backpressure: hold Out_Ready=0, push DEPTH+2 valid requests -> Req_Ready drops after DEPTH words are buffered. Release Out_Ready -> all words drain in order with none lost or duplicated; simultaneous push/pop on full keeps Req_Ready=1.
- Flush and reset: Flush with 3 words queued -> Out_Valid=0 next cycle, counters unchanged. Assert Reset mid-burst -> all outputs 0 immediately.
